// File: rtl/uart_rx_oversampled.sv
// UART receiver: two-flop synchronised rx, start-bit validation at mid-bit, mid-period sampling,
// optional parity, registered completion/framing/parity pulses.
module uart_rx_oversampled #(
   parameter int CLKS_PER_BIT = 16,
   parameter int PARITY_EN    = 0,
   parameter int PARITY_ODD   = 0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx,
   output logic [7:0] data_out,
   output logic       rx_done,
   output logic       frame_err,
   output logic       parity_err,
   output logic       busy
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

   logic [1:0]    sync_q, sync_d;
   logic [1:0]    fill_q, fill_d;
   logic          rx_prev_q, rx_prev_d;
   logic          armed_q, armed_d;
   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    idx_q, idx_d;
   logic [7:0]    shift_q, shift_d;
   logic          par_bad_q, par_bad_d;
   logic [7:0]    data_out_q, data_out_d;
   logic          rx_done_q, rx_done_d;
   logic          frame_err_q, frame_err_d;
   logic          parity_err_q, parity_err_d;
   logic          busy_q, busy_d;
   logic          rx_s, fall;

   assign rx_s = sync_q[1];
   // fill_q[1] marks that rx_s now reflects the real line rather than the reset value,
   // so a line held low across reset release never arms the receiver.
   assign fall = armed_q & rx_prev_q & ~rx_s;

   always_comb begin
      sync_d       = {sync_q[0], rx};
      fill_d       = {fill_q[0], 1'b1};
      rx_prev_d    = rx_s;
      armed_d      = armed_q | (fill_q[1] & rx_s);
      state_d      = state_q;
      cnt_d        = cnt_q + 1'b1;
      idx_d        = idx_q;
      shift_d      = shift_q;
      par_bad_d    = par_bad_q;
      data_out_d   = data_out_q;
      rx_done_d    = 1'b0;
      frame_err_d  = 1'b0;
      parity_err_d = 1'b0;
      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (fall) begin
               state_d   = START;
               idx_d     = 3'd0;
               par_bad_d = 1'b0;
            end
         end
         START: begin
            if (cnt_q == HALF_M1) begin
               cnt_d   = '0;
               state_d = rx_s ? IDLE : DATA;
            end
         end
         DATA: begin
            if (cnt_q == FULL_M1) begin
               cnt_d          = '0;
               shift_d[idx_q] = rx_s;
               idx_d          = idx_q + 3'd1;
               if (idx_q == 3'd7) state_d = (PARITY_EN != 0) ? PARITY : STOP;
            end
         end
         PARITY: begin
            if (cnt_q == FULL_M1) begin
               cnt_d     = '0;
               par_bad_d = (^{shift_q, rx_s}) != (PARITY_ODD != 0);
               state_d   = STOP;
            end
         end
         STOP: begin
            if (cnt_q == FULL_M1) begin
               cnt_d   = '0;
               state_d = IDLE;
               // A low stop bit wins over any parity mismatch and keeps the old byte.
               if (rx_s) begin
                  data_out_d   = shift_q;
                  rx_done_d    = 1'b1;
                  parity_err_d = par_bad_q;
               end else begin
                  frame_err_d = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync_q       <= 2'b11;
         fill_q       <= 2'b00;
         rx_prev_q    <= 1'b1;
         armed_q      <= 1'b0;
         state_q      <= IDLE;
         cnt_q        <= '0;
         idx_q        <= 3'd0;
         shift_q      <= 8'h00;
         par_bad_q    <= 1'b0;
         data_out_q   <= 8'h00;
         rx_done_q    <= 1'b0;
         frame_err_q  <= 1'b0;
         parity_err_q <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         sync_q       <= sync_d;
         fill_q       <= fill_d;
         rx_prev_q    <= rx_prev_d;
         armed_q      <= armed_d;
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         idx_q        <= idx_d;
         shift_q      <= shift_d;
         par_bad_q    <= par_bad_d;
         data_out_q   <= data_out_d;
         rx_done_q    <= rx_done_d;
         frame_err_q  <= frame_err_d;
         parity_err_q <= parity_err_d;
         busy_q       <= busy_d;
      end
   end

   assign data_out   = data_out_q;
   assign rx_done    = rx_done_q;
   assign frame_err  = frame_err_q;
   assign parity_err = parity_err_q;
   assign busy       = busy_q;

endmodule

// File: doc/uart_rx_oversampled.md
# uart_rx_oversampled

Serial receive front end for the UART subsystem. It turns the asynchronous `rx` line back into bytes, taking the other end of the link from the transmitter driven by `data_in`/`send`. It synchronises the line, validates the start bit and samples each bit at mid-period. It returns 8-bit words with a completion pulse plus framing and parity error flags, and sits beside the transmitter under the UART top level.

## Interface
- `CLKS_PER_BIT`, default 16: clock cycles per bit period; must be even and ≥ 4.
- `PARITY_EN`, default 0: 1 inserts one parity bit between D7 and the stop bit.
- `PARITY_ODD`, default 0: parity sense when enabled (0 = even, 1 = odd).

Ports:
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `rx`  in  1  serial line; idle high, asynchronous to `clk`.
- `data_out`  out  8  last good byte; holds until the next good frame.
- `rx_done`  out  1  one-cycle pulse when `data_out` updates.
- `frame_err`  out  1  one-cycle pulse when the stop bit is sampled low.
- `parity_err`  out  1  one-cycle pulse, coincident with `rx_done`, on a parity mismatch.
- `busy`  out  1  high whenever the state is not IDLE.

## Operation
- Synchroniser: `rx` passes through two flops before use (`rx_s`), and both flops reset to 1.
- Arming: after reset the block ignores `rx_s` until it has seen `rx_s` = 1 for at least one cycle, so a line held low is not taken as a start bit.
- Frame format: LSB first, 1 start bit, 8 data bits, optional parity bit, 1 stop bit.
- The bit counter is `$clog2(CLKS_PER_BIT)` bits wide and the data-bit index is 3 bits.
- IDLE: when armed and `rx_s` falls from 1 to 0, clear the counter and go to START.
- START: count `CLKS_PER_BIT/2` cycles, then sample `rx_s`.
  - If the sample is 1, it is a glitch: return to IDLE with no outputs.
  - If the sample is 0, clear the counter and go to DATA.
- DATA: every `CLKS_PER_BIT` cycles, sample `rx_s` into the shift register at bit index 0..7.
  - After index 7, go to PARITY if `PARITY_EN`, otherwise go to STOP.
- PARITY: after `CLKS_PER_BIT` cycles, sample the bit.
  - The mismatch flag is set when `^{data, bit}` ≠ `PARITY_ODD`.
- STOP: after `CLKS_PER_BIT` cycles, sample the stop bit.
  - If it is 1: on the next edge load `data_out`, pulse `rx_done`, and pulse `parity_err` if the mismatch flag is set.
  - If it is 0: pulse `frame_err` and leave `data_out` unchanged. `rx_done` and `parity_err` are suppressed, because a framing error overrides a parity error.
- After STOP, return to IDLE. A new start is recognised only on a fresh 1→0 edge of `rx_s`, so a break condition (line held low) produces exactly one `frame_err`.
- Activity on `rx` while `busy` is high is consumed as part of the current frame; there is no re-synchronisation mid-frame.

## Timing
- Reset values:
  - `data_out` = 0x00; `rx_done`, `frame_err`, `parity_err` = 0; `busy` = 0.
  - State = IDLE, unarmed; synchroniser = 1.
- Let `rx` fall at edge 0, with setup met. Let N = `CLKS_PER_BIT` and P = `PARITY_EN`.
  - `rx_s` is low at edge 2, and START is entered at edge 3 (`busy` = 1 from edge 3).
  - The start sample is taken at edge 3 + N/2.
  - Data bit i is sampled at edge 3 + N/2 + N·(i+1).
  - The stop-bit sample is taken at edge 3 + N/2 + N·(9+P).
  - `rx_done`/`frame_err` are high for exactly the one cycle following that sample edge.
  - `busy` returns to 0 in the same cycle.
- For N = 16 and P = 0, the stop-bit sample is taken at edge 155 and the completion pulse follows it.
- Back-to-back frames: a start edge arriving in the cycle that `busy` falls is accepted, giving zero idle bits between frames.
- Reset asserted mid-frame clears everything immediately. The partial byte is discarded and no pulse is produced.
- All outputs are registered and there is no combinational path from `rx`.

## Test plan
- Reset check, N = 16, P = 0:
  - After `rst` is released with `rx` = 1, all outputs are zero.
  - Send 0x6A as 0,0,1,0,1,0,1,1,0,1 at 16 clocks per bit.
  - Expect `rx_done` for exactly one cycle at the computed edge, `data_out` = 0x6A, and `frame_err` = 0.
- Back-to-back frames:
  - Send 0x00, 0xFF and 0xA5 with no idle gap.
  - Expect three `rx_done` pulses spaced exactly 160 clocks apart, with `data_out` = 0x00, then 0xFF, then 0xA5.
- Glitch rejection: drive `rx` low for 4 clocks, then high.
  - Expect `busy` to pulse, then return to IDLE with no `rx_done`/`frame_err` and `data_out` unchanged.
- Framing error: send 0x3C with the stop bit 0, then hold `rx` low for 40 bit times, then release it.
  - Expect exactly one `frame_err`, no `rx_done`, and `data_out` still holding the previous value.
  - A following 0x81 frame is then received correctly.
- Parity, with P = 1 and `PARITY_ODD` = 0:
  - Send 0x07 with parity bit 1: expect `rx_done` with `parity_err` = 0.
  - Send 0x07 with parity bit 0: expect `rx_done`, `parity_err` = 1 in the same cycle, and `data_out` = 0x07.
- Reset mid-frame: assert `rst` during bit 4 of 0x55.
  - Expect all outputs to be 0 immediately and no pulse.
  - With `rx` held low through the release, the block stays in IDLE until `rx` returns high, and the next frame, 0x12, is received correctly.
